// File: rtl/com_pkg.sv
// Shared types and width helpers for the multi-channel centre-of-mass tracker.
package com_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, PUBLISH} com_state_t;

    // Pixel count width: enough for a full H x V frame.
    function automatic int cw(input int h, input int v);
        return h + v;
    endfunction

    // Divider width: wide enough for sum-x, the widest dividend.
    function automatic int dw(input int h, input int v);
        return 2 * h + v;
    endfunction

endpackage

// File: rtl/com_divider.sv
// Restoring radix-2 serial divider: 1 load cycle, WIDTH iterations, 1 done cycle.
module com_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic             done_out
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   trial;
    logic             ge;

    // Divisor 0 makes every trial succeed, yielding an all-ones quotient.
    assign trial = {rem, quo[WIDTH-1]};
    assign ge    = trial >= {1'b0, dvs};
    assign quotient_out = quo;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (start_in) begin
                rem <= '0;
                quo <= dividend_in;
                dvs <= divisor_in;
                cnt <= CNT_W'(WIDTH);
            end else if (cnt != '0) begin
                rem <= ge ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ge};
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) done_out <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_center_of_mass.sv
// Per-frame centroid tracker for CHANNELS masks; one shared divider runs the
// per-channel x/y divisions serially after each tabulate pulse.
module multi_center_of_mass
    import com_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int H_WIDTH   = 11,
    parameter int V_WIDTH   = 10,
    parameter int MIN_COUNT = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [H_WIDTH-1:0]            x_in,
    input  logic [V_WIDTH-1:0]            y_in,
    input  logic [CHANNELS-1:0]           valid_in,
    input  logic                          tabulate_in,
    output logic [CHANNELS*H_WIDTH-1:0]   x_out,
    output logic [CHANNELS*V_WIDTH-1:0]   y_out,
    output logic [CHANNELS-1:0]           found_out,
    output logic                          valid_out,
    output logic                          busy_out,
    output logic                          overrun_out
);
    localparam int CW  = cw(H_WIDTH, V_WIDTH);
    localparam int SXW = CW + H_WIDTH;
    localparam int SYW = CW + V_WIDTH;
    localparam int DW  = dw(H_WIDTH, V_WIDTH);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    com_state_t state;
    logic [CHW-1:0] ch;

    logic [CHANNELS-1:0][CW-1:0]  sh_cnt;
    logic [CHANNELS-1:0][SXW-1:0] sh_sx;
    logic [CHANNELS-1:0][SYW-1:0] sh_sy;

    logic                 snap;
    assign snap = tabulate_in && (state == IDLE);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CW-1:0]  acc_cnt, shd_cnt;
        logic [SXW-1:0] acc_sx,  shd_sx;
        logic [SYW-1:0] acc_sy,  shd_sy;

        // The pixel arriving with tabulate_in seeds the new frame.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                acc_cnt <= '0; acc_sx <= '0; acc_sy <= '0;
                shd_cnt <= '0; shd_sx <= '0; shd_sy <= '0;
            end else begin
                if (snap) begin
                    shd_cnt <= acc_cnt; shd_sx <= acc_sx; shd_sy <= acc_sy;
                end
                if (tabulate_in) begin
                    acc_cnt <= CW'(valid_in[c]);
                    acc_sx  <= valid_in[c] ? SXW'(x_in) : '0;
                    acc_sy  <= valid_in[c] ? SYW'(y_in) : '0;
                end else if (valid_in[c]) begin
                    acc_cnt <= acc_cnt + 1'b1;
                    acc_sx  <= acc_sx + SXW'(x_in);
                    acc_sy  <= acc_sy + SYW'(y_in);
                end
            end
        end

        assign sh_cnt[c] = shd_cnt;
        assign sh_sx[c]  = shd_sx;
        assign sh_sy[c]  = shd_sy;
    end

    logic          div_start, div_done;
    logic [DW-1:0] div_q, div_dividend, div_divisor;

    assign div_dividend = (state == DIV_Y) ? DW'(sh_sy[ch]) : DW'(sh_sx[ch]);
    assign div_divisor  = DW'(sh_cnt[ch]);

    com_divider #(.WIDTH(DW)) u_div (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (div_start),
        .dividend_in (div_dividend),
        .divisor_in  (div_divisor),
        .quotient_out(div_q),
        .done_out    (div_done)
    );

    logic unused_q;
    assign unused_q = &{1'b0, div_q[DW-1:H_WIDTH]};

    logic [CHANNELS-1:0]              found_next, pub_en;
    logic [CHANNELS-1:0][H_WIDTH-1:0] stage_x;
    logic [CHANNELS-1:0][V_WIDTH-1:0] stage_y;

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            ch          <= '0;
            div_start   <= 1'b0;
            found_next  <= '0;
            pub_en      <= '0;
            stage_x     <= '0;
            stage_y     <= '0;
            x_out       <= '0;
            y_out       <= '0;
            found_out   <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            div_start   <= 1'b0;
            overrun_out <= tabulate_in && (state != IDLE);
            case (state)
                IDLE: if (tabulate_in) begin
                    state <= LOAD;
                    ch    <= '0;
                end
                LOAD: begin
                    found_next[ch] <= sh_cnt[ch] >= CW'(MIN_COUNT);
                    pub_en[ch]     <= (sh_cnt[ch] >= CW'(MIN_COUNT)) && (sh_cnt[ch] != '0);
                    div_start      <= 1'b1;
                    state          <= DIV_X;
                end
                DIV_X: if (div_done) begin
                    stage_x[ch] <= div_q[H_WIDTH-1:0];
                    div_start   <= 1'b1;
                    state       <= DIV_Y;
                end
                DIV_Y: if (div_done) begin
                    stage_y[ch] <= div_q[V_WIDTH-1:0];
                    if (ch == CHW'(CHANNELS - 1)) begin
                        state <= PUBLISH;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= LOAD;
                    end
                end
                PUBLISH: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (pub_en[c]) begin
                            x_out[c*H_WIDTH +: H_WIDTH] <= stage_x[c];
                            y_out[c*V_WIDTH +: V_WIDTH] <= stage_y[c];
                        end
                    end
                    found_out <= found_next;
                    valid_out <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_center_of_mass.sv
// Randomised scoreboard bench for multi_center_of_mass against a frame-level arithmetic model.
module tb_multi_center_of_mass;
    localparam int NC = 3, HW = 11, VW = 10, MINC = 16;
    localparam int LAT = 208;

    logic clk = 0, rst_n = 0;
    logic [HW-1:0] x_in = '0;
    logic [VW-1:0] y_in = '0;
    logic [NC-1:0] valid_in = '0;
    logic tabulate_in = 0;
    logic [NC*HW-1:0] x_out;
    logic [NC*VW-1:0] y_out;
    logic [NC-1:0] found_out;
    logic valid_out, busy_out, overrun_out;

    multi_center_of_mass #(.CHANNELS(NC), .H_WIDTH(HW), .V_WIDTH(VW), .MIN_COUNT(MINC)) dut (
        .clk_in(clk), .rst_in(rst_n), .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
        .tabulate_in(tabulate_in), .x_out(x_out), .y_out(y_out), .found_out(found_out),
        .valid_out(valid_out), .busy_out(busy_out), .overrun_out(overrun_out));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int               at;
        logic [NC*HW-1:0] x;
        logic [NC*VW-1:0] y;
        logic [NC-1:0]    f;
    } exp_t;
    exp_t exp_q[$];
    int   ovr_q[$];

    longint m_cnt[NC], m_sx[NC], m_sy[NC];
    int held_x[NC], held_y[NC];
    int last_acc = -100000;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0d req=%0d @edge %0d", n, act, req, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0; m_sx[c] = 0; m_sy[c] = 0; held_x[c] = 0; held_y[c] = 0;
        end
        last_acc = -100000;
        exp_q.delete();
        ovr_q.delete();
    endtask

    // One pixel clock: drive, let the edge sample it, then update the frame model.
    task automatic step(input int x, input int y, input logic [NC-1:0] m, input logic tab);
        exp_t e;
        x_in = HW'(x); y_in = VW'(y); valid_in = m; tabulate_in = tab;
        @(posedge clk); #1;
        if (tab) begin
            if (edge_n - last_acc <= LAT) begin
                ovr_q.push_back(edge_n);
            end else begin
                e.at = edge_n + LAT; e.x = '0; e.y = '0; e.f = '0;
                for (int c = 0; c < NC; c++) begin
                    e.f[c] = (m_cnt[c] >= MINC);
                    if (e.f[c] && m_cnt[c] > 0) begin
                        held_x[c] = int'((m_sx[c] / m_cnt[c]) % (1 << HW));
                        held_y[c] = int'((m_sy[c] / m_cnt[c]) % (1 << VW));
                    end
                    e.x[c*HW +: HW] = HW'(held_x[c]);
                    e.y[c*VW +: VW] = VW'(held_y[c]);
                end
                exp_q.push_back(e);
                last_acc = edge_n;
            end
            for (int c = 0; c < NC; c++) begin
                m_cnt[c] = m[c] ? 1 : 0;
                m_sx[c]  = m[c] ? x : 0;
                m_sy[c]  = m[c] ? y : 0;
            end
        end else begin
            for (int c = 0; c < NC; c++) if (m[c]) begin
                m_cnt[c]++; m_sx[c] += x; m_sy[c] += y;
            end
        end
        valid_in = '0; tabulate_in = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            int d;
            exp_t e;
            d = edge_n - last_acc;
            chk("busy", 64'(busy_out), 64'(d >= 0 && d < LAT));
            if (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
                chk("valid_missing", 64'(exp_q[0].at), 64'(edge_n));
                void'(exp_q.pop_front());
            end
            if (ovr_q.size() > 0 && ovr_q[0] < edge_n) begin
                chk("overrun_missing", 64'(ovr_q[0]), 64'(edge_n));
                void'(ovr_q.pop_front());
            end
            if (valid_out) begin
                if (exp_q.size() == 0) chk("valid_unexpected", 64'(1), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("valid_edge", 64'(edge_n), 64'(e.at));
                    chk("x_out", 64'(x_out), 64'(e.x));
                    chk("y_out", 64'(y_out), 64'(e.y));
                    chk("found_out", 64'(found_out), 64'(e.f));
                end
            end
            if (overrun_out) begin
                if (ovr_q.size() == 0) chk("overrun_unexpected", 64'(1), 64'(0));
                else chk("overrun_edge", 64'(edge_n), 64'(ovr_q.pop_front()));
            end
        end
    end

    initial begin
        logic [HW-1:0] xv;
        logic [VW-1:0] yv;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", 64'(x_out), 0);
        chk("rst_y", 64'(y_out), 0);
        chk("rst_found", 64'(found_out), 0);
        chk("rst_valid", 64'(valid_out), 0);
        chk("rst_busy", 64'(busy_out), 0);
        chk("rst_overrun", 64'(overrun_out), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Empty frame.
        step(0, 0, '0, 1); idle(230);
        chk("empty_found", 64'(found_out), 0);

        // 4x4 block on ch0.
        for (int y = 50; y < 54; y++) for (int x = 100; x < 104; x++) step(x, y, 3'b001, 0);
        step(0, 0, '0, 1); idle(230);
        xv = x_out[HW-1:0]; yv = y_out[VW-1:0];
        chk("blk_x0", 64'(xv), 101);
        chk("blk_y0", 64'(yv), 51);
        chk("blk_found", 64'(found_out), 3'b001);

        // Too few pixels: position held, not found.
        for (int i = 0; i < 10; i++) step(200 + i, 300, 3'b001, 0);
        step(0, 0, '0, 1); idle(230);
        xv = x_out[HW-1:0]; yv = y_out[VW-1:0];
        chk("few_found", 64'(found_out), 0);
        chk("few_x0_held", 64'(xv), 101);
        chk("few_y0_held", 64'(yv), 51);

        // All channels over a 64x48 block.
        for (int y = 0; y < 48; y++) for (int x = 0; x < 64; x++) step(x, y, 3'b111, 0);
        step(0, 0, '0, 1); idle(230);
        for (int c = 0; c < NC; c++) begin
            xv = x_out[c*HW +: HW]; yv = y_out[c*VW +: VW];
            chk("full_x", 64'(xv), 31);
            chk("full_y", 64'(yv), 23);
        end
        chk("full_found", 64'(found_out), 3'b111);

        // Overrun: second tabulate 50 cycles after the first.
        for (int i = 0; i < 40; i++) step(500 + i, 400, 3'b011, 0);
        step(7, 9, 3'b111, 1);
        for (int i = 0; i < 49; i++) step($urandom_range(0, 2047), $urandom_range(0, 1023), 3'($urandom), 0);
        step(3, 4, 3'b100, 1);
        for (int i = 0; i < 100; i++) step($urandom_range(0, 2047), $urandom_range(0, 1023), 3'($urandom), 0);
        idle(120);
        step(0, 0, '0, 1); idle(230);

        // Random frames with random spacing (some tabulates land while busy).
        for (int f = 0; f < 6; f++) begin
            step(2047, 1023, 3'b111, 0);
            for (int i = 0, n = $urandom_range(20, 300); i < n; i++)
                step($urandom_range(0, 2047), $urandom_range(0, 1023), 3'($urandom), 0);
            step($urandom_range(0, 2047), $urandom_range(0, 1023), 3'($urandom), 1);
            idle($urandom_range(100, 260));
        end
        idle(230);

        // Reset in the middle of a division.
        for (int i = 0; i < 30; i++) step(1000 + i, 600, 3'b111, 0);
        step(0, 0, '0, 1);
        idle(100);
        #1 rst_n = 0;
        #1;
        chk("midrst_x", 64'(x_out), 0);
        chk("midrst_y", 64'(y_out), 0);
        chk("midrst_found", 64'(found_out), 0);
        chk("midrst_valid", 64'(valid_out), 0);
        chk("midrst_busy", 64'(busy_out), 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Fresh frame after reset.
        for (int y = 10; y < 15; y++) for (int x = 20; x < 24; x++) step(x, y, 3'b010, 0);
        step(0, 0, '0, 1); idle(230);
        xv = x_out[HW +: HW]; yv = y_out[VW +: VW];
        chk("post_x1", 64'(xv), 21);
        chk("post_y1", 64'(yv), 12);
        chk("post_found", 64'(found_out), 3'b010);

        chk("exp_q_empty", 64'(exp_q.size()), 0);
        chk("ovr_q_empty", 64'(ovr_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout act=%0d req=0", edge_n);
        $fatal(1);
    end

endmodule
